// File: rtl/alien_fleet_ctrl_pkg.sv
// Shared definitions for the alien fleet controller.
// Contents:
//   - formation geometry (sprite size, grid size, derived pitches)
//   - state_t: controller state encoding, also exported for debug
package alien_fleet_ctrl_pkg;

  localparam int ALIENS_WIDTH  = 20;
  localparam int ALIENS_HEIGHT = 10;
  localparam int NUM_ROWS      = 4;
  localparam int NUM_COLS      = 8;

  // Aliens sit on a grid twice their own size; the origin is the centre of
  // alien (0,0), so a sprite extends half its size either side of its slot.
  localparam int COL_PITCH = 2 * ALIENS_WIDTH;
  localparam int ROW_PITCH = 2 * ALIENS_HEIGHT;
  localparam int HALF_W    = ALIENS_WIDTH / 2;
  localparam int HALF_H    = ALIENS_HEIGHT / 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } state_t;

endpackage

// File: rtl/alien_fleet_ctrl_if.sv
// Bundle between the game logic (master) and the fleet controller (slave).
// Signals:
//   start, frame_tick, hit_valid, hit_idx : requests into the controller
//   xAlien, yAlien, alive                 : formation seen by the renderer
//   dir_right, running, cleared, landed   : status
//   dbg_state                             : current controller state
//
// Handshake: every request is a single-cycle pulse sampled on the rising clk
// edge; there is no ready/back-pressure, the controller accepts every pulse in
// the cycle it is presented (or deliberately ignores it in non-MARCH states).
interface alien_fleet_ctrl_if;
  import alien_fleet_ctrl_pkg::*;

  logic        start;
  logic        frame_tick;
  logic        hit_valid;
  logic [4:0]  hit_idx;
  logic [9:0]  xAlien;
  logic [9:0]  yAlien;
  logic [31:0] alive;
  logic        dir_right;
  logic        running;
  logic        cleared;
  logic        landed;
  state_t      dbg_state;

  modport master (
    output start, frame_tick, hit_valid, hit_idx,
    input  xAlien, yAlien, alive, dir_right, running, cleared, landed, dbg_state
  );

  modport slave (
    input  start, frame_tick, hit_valid, hit_idx,
    output xAlien, yAlien, alive, dir_right, running, cleared, landed, dbg_state
  );

endinterface

// File: rtl/alien_occupancy.sv
// Combinational summary of the alive mask (bit 8*row+col).
// Ports:
//   alive     in  32  alive mask
//   cmin      out 3   leftmost column with a live alien (0 if none)
//   cmax      out 3   rightmost column with a live alien (0 if none)
//   rmax      out 2   lowest row with a live alien (0 if none)
//   popcount  out 6   number of live aliens
//   any_alive out 1   at least one alien alive
module alien_occupancy
  import alien_fleet_ctrl_pkg::*;
(
  input  logic [31:0] alive,
  output logic [2:0]  cmin,
  output logic [2:0]  cmax,
  output logic [1:0]  rmax,
  output logic [5:0]  popcount,
  output logic        any_alive
);

  logic [NUM_COLS-1:0] col_live;
  logic [NUM_ROWS-1:0] row_live;

  always_comb begin
    col_live = '0;
    row_live = '0;
    popcount = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (alive[r*NUM_COLS+c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
        popcount = popcount + 6'(alive[r*NUM_COLS+c]);
      end
    end

    // Scan direction picks the extreme: the last match wins.
    cmin = '0;
    cmax = '0;
    rmax = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_live[c]) cmin = 3'(c);
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_live[c]) cmax = 3'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_live[r]) rmax = 2'(r);
    end
    any_alive = |alive;
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien fleet controller: owns the formation origin and alive mask, marches
// the fleet left/right on frame ticks, drops it a row at the live edge,
// removes hit aliens and reports wave-cleared / fleet-landed.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   bus    slave side of alien_fleet_ctrl_if (requests in, formation/status out)
module alien_fleet_ctrl
  import alien_fleet_ctrl_pkg::*;
#(
  parameter logic [9:0] X_INIT     = 10'd100,
  parameter logic [9:0] Y_INIT     = 10'd40,
  parameter logic [9:0] X_MIN      = 10'd8,
  parameter logic [9:0] X_MAX      = 10'd631,
  parameter logic [9:0] STEP_X     = 10'd4,
  parameter logic [9:0] STEP_Y     = 10'd10,
  parameter logic [9:0] Y_LIMIT    = 10'd440,
  parameter logic [7:0] MIN_PERIOD = 8'd1
)(
  input  logic               clk,
  input  logic               reset,
  alien_fleet_ctrl_if.slave  bus
);

  // Period of a full formation, loaded by start without consulting the mask.
  localparam logic [7:0] FULL_PERIOD = MIN_PERIOD + 8'(NUM_ROWS * NUM_COLS / 4);

  state_t      state_q, state_n;
  logic [9:0]  x_q, x_n, y_q, y_n;
  logic [31:0] alive_q, alive_n;
  logic        dir_q, dir_n;
  logic [7:0]  cnt_q, cnt_n;

  logic [2:0]  cmin, cmax;
  logic [1:0]  rmax;
  logic [5:0]  popcount;
  logic        any_alive;
  logic [7:0]  period;

  // Edges of the live formation, computed from the registered (pre-hit) mask.
  logic signed [10:0] edge_l, edge_r, edge_b, step_l, step_r;

  alien_occupancy u_occ (
    .alive     (alive_q),
    .cmin      (cmin),
    .cmax      (cmax),
    .rmax      (rmax),
    .popcount  (popcount),
    .any_alive (any_alive)
  );

  assign period = MIN_PERIOD + 8'(popcount >> 2);
  assign edge_l = $signed(11'(x_q) + 11'(cmin) * 11'(COL_PITCH) - 11'(HALF_W));
  assign edge_r = $signed(11'(x_q) + 11'(cmax) * 11'(COL_PITCH) + 11'(HALF_W));
  assign edge_b = $signed(11'(y_q) + 11'(rmax) * 11'(ROW_PITCH) + 11'(HALF_H));
  assign step_l = edge_l - $signed(11'(STEP_X));
  assign step_r = edge_r + $signed(11'(STEP_X));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      alive_q <= '1;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      alive_q <= alive_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    alive_n = alive_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;

    if (bus.start) begin
      state_n = ST_MARCH;
      x_n     = X_INIT;
      y_n     = Y_INIT;
      alive_n = '1;
      dir_n   = 1'b1;
      cnt_n   = FULL_PERIOD;
    end else if (state_q == ST_MARCH) begin
      if (bus.hit_valid) alive_n[bus.hit_idx] = 1'b0;

      // An empty or landed formation leaves MARCH on this edge and does not
      // move again; a landing is only reachable through a drop, so it is
      // seen the cycle after that drop.
      if (!any_alive) begin
        state_n = ST_CLEARED;
      end else if (edge_b >= $signed(11'(Y_LIMIT))) begin
        state_n = ST_LANDED;
      end else if (bus.frame_tick) begin
        if (cnt_q <= 8'd1) begin
          cnt_n = period;
          if (dir_q) begin
            if (step_r > $signed(11'(X_MAX))) begin
              y_n   = y_q + STEP_Y;
              dir_n = 1'b0;
            end else begin
              x_n = x_q + STEP_X;
            end
          end else begin
            if (step_l < $signed(11'(X_MIN))) begin
              y_n   = y_q + STEP_Y;
              dir_n = 1'b1;
            end else begin
              x_n = x_q - STEP_X;
            end
          end
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
    end
  end

  assign bus.xAlien    = x_q;
  assign bus.yAlien    = y_q;
  assign bus.alive     = alive_q;
  assign bus.dir_right = dir_q;
  assign bus.running   = (state_q == ST_MARCH);
  assign bus.cleared   = (state_q == ST_CLEARED);
  assign bus.landed    = (state_q == ST_LANDED);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Testbench for alien_fleet_ctrl: table of directed vectors, hand-written
// edge/clear/land/reset sequences, and random traffic against a reference model.
module tb_alien_fleet_ctrl;

  localparam int M_IDLE    = 0;
  localparam int M_MARCH   = 1;
  localparam int M_CLEARED = 2;
  localparam int M_LANDED  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alien_fleet_ctrl_if bus ();

  alien_fleet_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          m_mode;
  int          m_x, m_y, m_cnt;
  logic [31:0] m_alive;
  bit          m_dir;

  function automatic int col_min(input logic [31:0] a);
    int res = -1;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        if (a[r*8+c] && res < 0) res = c;
    return (res < 0) ? 0 : res;
  endfunction

  function automatic int col_max(input logic [31:0] a);
    int res = 0;
    for (int i = 0; i < 32; i++) if (a[i] && (i % 8) > res) res = i % 8;
    return res;
  endfunction

  function automatic int row_max(input logic [31:0] a);
    int res = 0;
    for (int i = 0; i < 32; i++) if (a[i] && (i / 8) > res) res = i / 8;
    return res;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 100; m_y = 40; m_alive = '1; m_dir = 1; m_cnt = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit hv, input int hi);
    logic [31:0] pre;
    if (st) begin
      m_mode = M_MARCH; m_x = 100; m_y = 40; m_alive = '1; m_dir = 1;
      m_cnt = 1 + 32 / 4;
    end else if (m_mode == M_MARCH) begin
      pre = m_alive;
      if (hv) m_alive[hi] = 1'b0;
      if (pre == 0) m_mode = M_CLEARED;
      else if (m_y + 20 * row_max(pre) + 5 >= 440) m_mode = M_LANDED;
      else if (tk) begin
        if (m_cnt == 1) begin
          if (m_dir) begin
            if (m_x + 40 * col_max(pre) + 10 + 4 > 631) begin m_y += 10; m_dir = 0; end
            else m_x += 4;
          end else begin
            if (m_x + 40 * col_min(pre) - 10 - 4 < 8) begin m_y += 10; m_dir = 1; end
            else m_x -= 4;
          end
          m_cnt = 1 + $countones(pre) / 4;
        end else begin
          m_cnt--;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    exp_q.push_back(32'(m_x));
    exp_q.push_back(32'(m_y));
    exp_q.push_back(m_alive);
    exp_q.push_back(32'(m_dir));
    exp_q.push_back(32'(m_mode == M_MARCH));
    exp_q.push_back(32'(m_mode == M_CLEARED));
    exp_q.push_back(32'(m_mode == M_LANDED));
    chk("model_x",       32'(bus.xAlien),    exp_q.pop_front());
    chk("model_y",       32'(bus.yAlien),    exp_q.pop_front());
    chk("model_alive",   bus.alive,          exp_q.pop_front());
    chk("model_dir",     32'(bus.dir_right), exp_q.pop_front());
    chk("model_running", 32'(bus.running),   exp_q.pop_front());
    chk("model_cleared", 32'(bus.cleared),   exp_q.pop_front());
    chk("model_landed",  32'(bus.landed),    exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; presents one cycle of inputs.
  task automatic step(input bit st, input bit tk, input bit hv, input logic [4:0] hi);
    bus.start = st; bus.frame_tick = tk; bus.hit_valid = hv; bus.hit_idx = hi;
    @(posedge clk);
    model_step(st, tk, hv, int'(hi));
    #1;
    check_model();
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.hit_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          st, tk, hv;
    logic [4:0]  hi;
    logic [9:0]  ex, ey;
    logic [31:0] ea;
    bit          edir, erun;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit st, input bit tk, input bit hv, input logic [4:0] hi,
                         input logic [9:0] ex, input logic [31:0] ea, input bit erun);
    vec_t v;
    v.st = st; v.tk = tk; v.hv = hv; v.hi = hi;
    v.ex = ex; v.ey = 10'd40; v.ea = ea; v.edir = 1'b1; v.erun = erun;
    vq.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.hit_valid = 1'b0; bus.hit_idx = '0;
    model_reset();
    #2;
    chk("rst_x",       32'(bus.xAlien),    32'd100);
    chk("rst_y",       32'(bus.yAlien),    32'd40);
    chk("rst_alive",   bus.alive,          32'hFFFF_FFFF);
    chk("rst_dir",     32'(bus.dir_right), 32'd1);
    chk("rst_running", 32'(bus.running),   32'd0);
    chk("rst_cleared", 32'(bus.cleared),   32'd0);
    chk("rst_landed",  32'(bus.landed),    32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Hit and tick in IDLE ignored; start; 9 ticks for first move; double hit.
    add_vec(0, 0, 1, 5'd5, 10'd100, 32'hFFFF_FFFF, 0);
    add_vec(0, 1, 0, 5'd0, 10'd100, 32'hFFFF_FFFF, 0);
    add_vec(1, 0, 0, 5'd0, 10'd100, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 8; i++) add_vec(0, 1, 0, 5'd0, 10'd100, 32'hFFFF_FFFF, 1);
    add_vec(0, 1, 0, 5'd0, 10'd104, 32'hFFFF_FFFF, 1);
    add_vec(0, 0, 1, 5'd5, 10'd104, 32'hFFFF_FFDF, 1);
    add_vec(0, 0, 1, 5'd5, 10'd104, 32'hFFFF_FFDF, 1);
    add_vec(0, 0, 0, 5'd0, 10'd104, 32'hFFFF_FFDF, 1);
    foreach (vq[i]) begin
      step(vq[i].st, vq[i].tk, vq[i].hv, vq[i].hi);
      chk($sformatf("vec%0d_x", i),     32'(bus.xAlien),    32'(vq[i].ex));
      chk($sformatf("vec%0d_y", i),     32'(bus.yAlien),    32'(vq[i].ey));
      chk($sformatf("vec%0d_alive", i), bus.alive,          vq[i].ea);
      chk($sformatf("vec%0d_dir", i),   32'(bus.dir_right), 32'(vq[i].edir));
      chk($sformatf("vec%0d_run", i),   32'(bus.running),   32'(vq[i].erun));
    end

    // Full formation reaches the right edge: R = x+290, drop when x = 340.
    step(1, 0, 0, 5'd0);
    n = 0;
    while (m_y == 40 && n < 2000) begin step(0, 1, 0, 5'd0); n++; end
    chk("dropA_bound", 32'(n < 2000), 32'd1);
    chk("dropA_x",   32'(bus.xAlien),    32'd340);
    chk("dropA_y",   32'(bus.yAlien),    32'd50);
    chk("dropA_dir", 32'(bus.dir_right), 32'd0);

    // Columns 6,7 killed: R = x+210, drop when x = 420.
    step(1, 0, 0, 5'd0);
    for (int r = 0; r < 4; r++) begin
      step(0, 0, 1, 5'(r * 8 + 6));
      step(0, 0, 1, 5'(r * 8 + 7));
    end
    chk("dropB_alive", bus.alive, 32'h3F3F_3F3F);
    n = 0;
    while (m_y == 40 && n < 2000) begin step(0, 1, 0, 5'd0); n++; end
    chk("dropB_bound", 32'(n < 2000), 32'd1);
    chk("dropB_x",   32'(bus.xAlien),    32'd420);
    chk("dropB_y",   32'(bus.yAlien),    32'd50);
    chk("dropB_dir", 32'(bus.dir_right), 32'd0);

    // Kill all 32: cleared one cycle after the last hit, then frozen.
    step(1, 0, 0, 5'd0);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 5'(i));
    chk("clr_alive",   bus.alive,        32'd0);
    chk("clr_pending", 32'(bus.running), 32'd1);
    step(0, 0, 0, 5'd0);
    chk("clr_cleared", 32'(bus.cleared), 32'd1);
    chk("clr_running", 32'(bus.running), 32'd0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 5'(i));
    chk("clr_x", 32'(bus.xAlien), 32'd100);
    chk("clr_y", 32'(bus.yAlien), 32'd40);

    // Two aliens on the bottom row spanning full width: march until landed.
    step(1, 0, 0, 5'd0);
    for (int i = 0; i < 32; i++) if (i != 24 && i != 31) step(0, 0, 1, 5'(i));
    chk("land_alive", bus.alive, 32'h8100_0000);
    n = 0;
    while (m_mode != M_LANDED && n < 6000) begin step(0, 1, 0, 5'd0); n++; end
    chk("land_bound",   32'(n < 6000),      32'd1);
    chk("land_landed",  32'(bus.landed),    32'd1);
    chk("land_running", 32'(bus.running),   32'd0);
    chk("land_y",       32'(bus.yAlien),    32'd380);
    chk("land_x",       32'(bus.xAlien),    32'd20);
    chk("land_dir",     32'(bus.dir_right), 32'd1);
    step(0, 1, 0, 5'd0);
    chk("land_frozen_x", 32'(bus.xAlien), 32'd20);
    step(1, 0, 0, 5'd0);
    chk("restart_x",      32'(bus.xAlien), 32'd100);
    chk("restart_y",      32'(bus.yAlien), 32'd40);
    chk("restart_alive",  bus.alive,       32'hFFFF_FFFF);
    chk("restart_landed", 32'(bus.landed), 32'd0);
    chk("restart_run",    32'(bus.running), 32'd1);

    // Reset in the middle of a march takes effect without a clock edge.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 5'd0);
    chk("mid_x", 32'(bus.xAlien), 32'd108);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_x",     32'(bus.xAlien),    32'd100);
    chk("arst_y",     32'(bus.yAlien),    32'd40);
    chk("arst_alive", bus.alive,          32'hFFFF_FFFF);
    chk("arst_dir",   32'(bus.dir_right), 32'd1);
    chk("arst_run",   32'(bus.running),   32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step((i == 0) || ($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0,
           5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
